pot_scan_ctrl: RTL
==================

// Module: pot_scan_ctrl
// PURPOSE
//  Round-robin scheduler that shares the single SPI A2D converter among the six slide pots
//  (LP, B1, B2, B3, HP, VOLUME). Sequences start-convert/complete handshakes with the SPI A2D
//  master and holds one 12-bit gain register per pot. Sits between the A2D SPI master and the
//  equalizer engine/LED logic. Adds a per-conversion watchdog and an inter-conversion gap.
// PARAMETERS
//  NUM_POTS        6      pots scanned per sweep; fixed by the channel map table
//  GAP_CYCLES      16     idle clk cycles between a store and the next strt_cnv (>=1)
//  TIMEOUT_CYCLES  4096   max clk cycles in WAIT before a conversion is abandoned
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  en          in   1   scan enable; low -> finish the current conversion, then park in IDLE
//  strt_cnv    out  1   one-cycle pulse to the A2D SPI master: start conversion on chnnl
//  chnnl       out  3   A2D channel for the current conversion; stable from strt_cnv to store
//  cnv_cmplt   in   1   one-cycle pulse from the A2D master: res is valid this cycle
//  res         in   12  conversion result
//  POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME   out  12 each   registered pot values
//  sweep_done  out  1   one-cycle pulse after the last pot of a sweep is stored or timed out
//  err         out  1   sticky: set on any timeout; cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE, slot=0, strt_cnv=0, chnnl=map[0], all pot registers=12'h000,
//   sweep_done=0, err=0, counters=0. Reset mid-conversion aborts; a later stray cnv_cmplt
//   in IDLE is ignored.
//  Channel map (slot -> chnnl): 0:LP=1, 1:B1=0, 2:B2=4, 3:B3=2, 4:HP=3, 5:VOL=7.
//  FSM (Moore outputs, all registered):
//   IDLE : en=1 -> START
//   START: strt_cnv=1 for exactly this cycle, chnnl=map[slot]; clear wdog -> WAIT
//   WAIT : wdog++ each cycle
//          cnv_cmplt=1 -> latch res into pot[slot] on this edge -> GAP
//          else wdog==TIMEOUT_CYCLES-1 -> err<=1, pot[slot] unchanged -> GAP
//          cnv_cmplt and timeout in the same cycle: cnv_cmplt wins, no err
//   GAP  : gap counter runs GAP_CYCLES cycles; on entry, slot<=slot+1 (wrap 5->0)
//          sweep_done pulses on the GAP entry cycle when leaving slot 5
//          at end: en=1 -> START; en=0 -> IDLE (slot retained; resume at next slot)
//  Latency: pot register updates on the clk edge at which cnv_cmplt=1 is sampled; visible
//   the next cycle. Start-to-start period = 1 + conversion + GAP_CYCLES.
//  en falling during WAIT/GAP has no effect until the end of GAP. cnv_cmplt outside WAIT ignored.
//  res is stored unmodified (no inversion/scaling); pot registers are only written in WAIT.
//  Exactly one pot register changes per store; the others hold.
// STRUCTURE
//  Package eq_pkg: typedef enum {IDLE,START,WAIT,GAP} scan_state_t; localparam
//   CH_MAP[0:5]; typedef logic [11:0] gain_t; pot slot index constants.
//  Single module; no sub-module. Pot storage is a 6x12 register array with named output slices.
//  The watchdog and gap use one shared down-counter, sized clog2(max(TIMEOUT,GAP)).
// TESTING
//  1 rst then en=1, model replies cnv_cmplt 40 cycles after each strt_cnv with res=12'h100+slot
//    -> chnnl sequence 1,0,4,2,3,7; POT_LP=0x100 ... VOLUME=0x105; sweep_done once per 6 stores.
//  2 Measure strt_cnv spacing with a 40-cycle model, GAP_CYCLES=16 -> 57 cycles; each strt_cnv
//    is 1 cycle wide.
//  3 Model never answers slot 2 -> after TIMEOUT_CYCLES err=1, POT_B2 holds its old value,
//    and the next strt_cnv uses chnnl=2 (B3).
//  4 cnv_cmplt on exactly the timeout cycle with res=0xABC -> POT stored 0xABC, err stays 0.
//  5 en dropped mid-WAIT on slot 3 -> slot 3 stored, then IDLE; en re-raised -> first
//    strt_cnv has chnnl=3 (slot 4).
//  6 rst asserted in WAIT, then cnv_cmplt pulse in IDLE -> all pots 0, no store,
//    strt_cnv stays 0 while en=0.

Source files
------------

// File: rtl/eq_pkg.sv
// eq_pkg.sv - shared types, channel map and slot constants for the pot scanner
//
// Purpose: common definitions for pot_scan_ctrl: FSM state encoding, the
//   slot -> A2D channel map, gain word type and named slot indices.
// Ports: none (package).
package eq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } scan_state_t;

  localparam int NUM_POTS = 6;
  localparam int SLOT_W   = 3;

  typedef logic [11:0]       gain_t;
  typedef logic [2:0]        chnnl_t;
  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t SLOT_LP   = 3'd0;
  localparam slot_t SLOT_B1   = 3'd1;
  localparam slot_t SLOT_B2   = 3'd2;
  localparam slot_t SLOT_B3   = 3'd3;
  localparam slot_t SLOT_HP   = 3'd4;
  localparam slot_t SLOT_VOL  = 3'd5;
  localparam slot_t SLOT_LAST = SLOT_VOL;

  // Board wiring: which A2D input each pot sits on, indexed by scan slot.
  localparam chnnl_t CH_MAP [0:NUM_POTS-1] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  function automatic chnnl_t slot_to_chnnl(input slot_t s);
    chnnl_t c;
    c = CH_MAP[0];
    case (s)
      SLOT_LP:  c = CH_MAP[0];
      SLOT_B1:  c = CH_MAP[1];
      SLOT_B2:  c = CH_MAP[2];
      SLOT_B3:  c = CH_MAP[3];
      SLOT_HP:  c = CH_MAP[4];
      SLOT_VOL: c = CH_MAP[5];
      default:  c = CH_MAP[0];
    endcase
    return c;
  endfunction

  function automatic slot_t next_slot(input slot_t s);
    return (s == SLOT_LAST) ? SLOT_LP : slot_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/pot_scan_ctrl.sv
// pot_scan_ctrl.sv - round-robin scheduler sharing one SPI A2D among six slide pots
//
// Purpose: sequences strt_cnv / cnv_cmplt handshakes with the A2D SPI master,
//   stores each result in a per-pot gain register, enforces a per-conversion
//   watchdog and an idle gap between conversions.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              scan enable (sampled in IDLE and at the end of GAP)
//   strt_cnv, chnnl start pulse and channel to the A2D master
//   cnv_cmplt, res  completion pulse and 12-bit result from the A2D master
//   POT_LP..VOLUME  registered gain values
//   sweep_done      pulse after slot 5 is stored or abandoned
//   err             sticky watchdog timeout flag
module pot_scan_ctrl
  import eq_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] POT_LP,
  output logic [11:0] POT_B1,
  output logic [11:0] POT_B2,
  output logic [11:0] POT_B3,
  output logic [11:0] POT_HP,
  output logic [11:0] VOLUME,
  output logic        sweep_done,
  output logic        err
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // The shared down-counter reaches zero on the last cycle of WAIT/GAP, so
  // both loads are "cycles - 1".
  localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  scan_state_t      state_q;
  slot_t            slot_q;
  logic [CNT_W-1:0] cnt_q;
  logic             strt_cnv_q;
  chnnl_t           chnnl_q;
  logic             sweep_done_q;
  logic             err_q;
  gain_t            pot_q [NUM_POTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= SLOT_LP;
      cnt_q        <= '0;
      strt_cnv_q   <= 1'b0;
      chnnl_q      <= CH_MAP[0];
      sweep_done_q <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < NUM_POTS; i++) begin
        pot_q[i] <= '0;
      end
    end else begin
      strt_cnv_q   <= 1'b0;
      sweep_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (en) begin
            state_q    <= START;
            strt_cnv_q <= 1'b1;
            chnnl_q    <= slot_to_chnnl(slot_q);
          end
        end
        START: begin
          state_q <= WAIT;
          cnt_q   <= WDOG_LOAD;
        end
        WAIT: begin
          // A completion on the timeout cycle still counts as a good store.
          if (cnv_cmplt || (cnt_q == '0)) begin
            if (cnv_cmplt) begin
              pot_q[slot_q] <= res;
            end else begin
              err_q <= 1'b1;
            end
            state_q      <= GAP;
            cnt_q        <= GAP_LOAD;
            slot_q       <= next_slot(slot_q);
            sweep_done_q <= (slot_q == SLOT_LAST);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            if (en) begin
              state_q    <= START;
              strt_cnv_q <= 1'b1;
              chnnl_q    <= slot_to_chnnl(slot_q);
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign strt_cnv   = strt_cnv_q;
  assign chnnl      = chnnl_q;
  assign sweep_done = sweep_done_q;
  assign err        = err_q;
  assign POT_LP     = pot_q[SLOT_LP];
  assign POT_B1     = pot_q[SLOT_B1];
  assign POT_B2     = pot_q[SLOT_B2];
  assign POT_B3     = pot_q[SLOT_B3];
  assign POT_HP     = pot_q[SLOT_HP];
  assign VOLUME     = pot_q[SLOT_VOL];

endmodule
